idli_ctrl_m: RTL
================

// Module: idli_ctrl_m
// PURPOSE
//  Sequencing/arbitration controller for the SQI memory port (idli_sqi_m); sits between fetch, LSU and the
//  SQI block in idli_top_m. Owns the 2-bit slice counter (ctr_t), issues boot/branch/data redirects.
//  Shares the single SQI port between sequential instruction fetch and LSU load/store words.
//  Gates SQI instruction-valid so decode only sees instructions fetched from the live stream.
// PARAMETERS
//  RESET_VEC   16'h0000  fetch address issued after reset
//  DUMMY_WORDS 1         idle words between read-address word and first read-data word (SQI wait)
// PORTS
//  i_ctrl_gck          in   1  core clock
//  i_ctrl_rst_n        in   1  reset; asynchronous, active-low
//  o_ctrl_ctr          out  2  slice counter to all blocks; 0..3 = LSB..MSB slice of a 16b word
//  i_ctrl_br_req       in   1  branch taken; sampled at ctr==3, held by requester until accepted
//  i_ctrl_br_slice     in   4  branch target, one slice per cycle, LSB first, valid during ctr 0..3
//  i_ctrl_pc_slice     in   4  current fetch PC, one slice per cycle (used for fetch resume)
//  i_ctrl_mem_req      in   1  LSU access request; sampled at ctr==3, held until o_ctrl_mem_ack
//  i_ctrl_mem_wr       in   1  1=store, 0=load; stable while i_ctrl_mem_req
//  i_ctrl_mem_addr     in   4  LSU address slice, LSB first, valid during MEM_ADDR word
//  i_ctrl_mem_wdata    in   4  store data slice, LSB first, valid during MEM_DATA word
//  o_ctrl_mem_ack      out  1  1-cycle pulse at ctr==3 of final MEM_DATA word
//  o_ctrl_mem_rvld     out  1  load data slice valid (4 cycles, ctr 0..3)
//  o_ctrl_mem_rdata    out  4  load data slice
//  o_ctrl_stall        out  1  core must hold architectural state (any state except FETCH)
//  o_ctrl_sqi_redirect out  1  to idli_sqi_m: new address follows on o_ctrl_sqi_slice
//  o_ctrl_sqi_wr_en    out  1  to idli_sqi_m: current word is write data
//  o_ctrl_sqi_slice    out  4  address/write-data slice to idli_sqi_m
//  i_ctrl_sqi_slice    in   4  read slice from idli_sqi_m
//  i_ctrl_sqi_ivld     in   1  raw instruction-valid from idli_sqi_m
//  o_ctrl_instr_vld    out  1  gated instruction-valid to decode
// BEHAVIOUR
//  - ctr_q: reset 0, +1 every cycle, wraps 3->0, never stalls. State changes only at ctr==3 (word edge).
//  - Reset values: state BOOT, all outputs 0 except o_ctrl_stall=1. Reset mid-word aborts everything.
//  - States (one word = 4 cycles each unless noted):
//    BOOT: redirect=1, slice=RESET_VEC[4c+:4] -> DISCARD.
//    DISCARD: stall=1, instr_vld forced 0 (SQI refill word) -> FETCH.
//    FETCH: stall=0, instr_vld=i_ctrl_sqi_ivld. At ctr==3: br_req -> BR_ADDR; else mem_req -> MEM_ADDR.
//    BR_ADDR: redirect=1, slice=i_ctrl_br_slice -> DISCARD.
//    MEM_ADDR: redirect=1, slice=i_ctrl_mem_addr -> MEM_DATA if store, else WAIT (DUMMY_WORDS words;
//      skipped if 0).
//    WAIT: counts words -> MEM_DATA.
//    MEM_DATA: store: wr_en=1, slice=i_ctrl_mem_wdata. Load: rvld=1, rdata=i_ctrl_sqi_slice.
//      ack at ctr==3 -> RESUME.
//    RESUME: redirect=1, slice=i_ctrl_pc_slice -> DISCARD.
//  - Priority at a FETCH word edge: branch over mem; unaccepted mem_req stays pending, served after branch
//    refill.
//  - br_req outside FETCH is ignored; requester re-presents it.
//  - o_ctrl_instr_vld is never 1 while stall=1. redirect and wr_en are mutually exclusive.
//  - Outputs combinational from state_q/ctr_q; no input-to-output path except slice muxes.
//  - Fetch latency after any redirect: 1 DISCARD word, then instructions flow.
// STRUCTURE
//  - idli_pkg: ctrl_state_t enum (BOOT,DISCARD,FETCH,BR_ADDR,MEM_ADDR,WAIT,MEM_DATA,RESUME),
//    RESET_VEC default; ctr_t/slice_t reused.
//  - Single module; no sub-module. idli_top_m drops its local counter and uses o_ctrl_ctr.
// TESTING
//  1 Reset release -> BOOT word drives slices 0,0,0,0 with redirect=1; instr_vld first high in word 3.
//  2 FETCH, br_req with target 16'hA5C3 -> redirect slices 3,C,5,A; one DISCARD word; stall 1 for 2 words.
//  3 Store addr 16'h1234 data 16'hBEEF -> addr slices 4,3,2,1; wr_en word slices F,E,E,B; ack;
//    RESUME drives PC.
//  4 Load, DUMMY_WORDS=1, SQI returns 16'h0F0F -> 1 wait word, rvld 4 cycles rdata F,0,F,0,
//    ack at ctr==3.
//  5 br_req and mem_req together -> branch first; mem_req served after DISCARD; ack exactly once.
//  6 Reset asserted mid MEM_DATA -> outputs to reset values at once; BOOT reissued; no ack, no wr_en.

Source files
------------

// File: rtl/idli_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idli_pkg
//  Description : Shared types for the idli core: slice counter, 4-bit slice,
//                controller state encoding and the default reset vector.
//  Revision    : 1.0  initial release
// ============================================================================
package idli_pkg;

    typedef logic [1:0] ctr_t;
    typedef logic [3:0] slice_t;

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        DISCARD  = 3'd1,
        FETCH    = 3'd2,
        BR_ADDR  = 3'd3,
        MEM_ADDR = 3'd4,
        WAIT     = 3'd5,
        MEM_DATA = 3'd6,
        RESUME   = 3'd7
    } ctrl_state_t;

    localparam logic [15:0] c_reset_vec = 16'h0000;

    // Pick slice c (0 = least significant nibble) out of a 16-bit word.
    function automatic slice_t word_slice(input logic [15:0] w, input ctr_t c);
        return w[{c, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/idli_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module      : idli_ctrl_m
//  Description : Sequencer/arbiter for the SQI memory port. Owns the slice
//                counter, issues boot/branch/data redirects and shares the
//                port between instruction fetch and LSU words.
//  Revision    : 1.0  initial release
// ============================================================================
module idli_ctrl_m
    import idli_pkg::*;
#(
    parameter logic [15:0] RESET_VEC   = c_reset_vec,
    parameter int          DUMMY_WORDS = 1
) (
    input  logic   i_ctrl_gck,
    input  logic   i_ctrl_rst_n,
    output ctr_t   o_ctrl_ctr,
    input  logic   i_ctrl_br_req,
    input  slice_t i_ctrl_br_slice,
    input  slice_t i_ctrl_pc_slice,
    input  logic   i_ctrl_mem_req,
    input  logic   i_ctrl_mem_wr,
    input  slice_t i_ctrl_mem_addr,
    input  slice_t i_ctrl_mem_wdata,
    output logic   o_ctrl_mem_ack,
    output logic   o_ctrl_mem_rvld,
    output slice_t o_ctrl_mem_rdata,
    output logic   o_ctrl_stall,
    output logic   o_ctrl_sqi_redirect,
    output logic   o_ctrl_sqi_wr_en,
    output slice_t o_ctrl_sqi_slice,
    input  slice_t i_ctrl_sqi_slice,
    input  logic   i_ctrl_sqi_ivld,
    output logic   o_ctrl_instr_vld
);

    localparam logic [7:0] c_wait_last = 8'(DUMMY_WORDS - 1);

    ctr_t        r_ctr;
    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        r_is_store;
    logic [7:0]  r_wait_cnt;
    logic        w_word_end;

    assign w_word_end = (r_ctr == 2'd3);
    assign o_ctrl_ctr = r_ctr;

    // State register plus the per-access bookkeeping that rides with it.
    always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
        if (!i_ctrl_rst_n) begin
            r_ctr      <= '0;
            r_state    <= BOOT;
            r_is_store <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_ctr   <= r_ctr + ctr_t'(1);
            r_state <= w_state_nxt;
            if (r_state == FETCH && w_word_end && w_state_nxt == MEM_ADDR) begin
                r_is_store <= i_ctrl_mem_wr;
            end
            if (r_state == MEM_ADDR) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT && w_word_end) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_word_end) begin
            case (r_state)
                BOOT:     w_state_nxt = DISCARD;
                DISCARD:  w_state_nxt = FETCH;
                FETCH: begin
                    if (i_ctrl_br_req) begin
                        w_state_nxt = BR_ADDR;
                    end else if (i_ctrl_mem_req) begin
                        w_state_nxt = MEM_ADDR;
                    end
                end
                BR_ADDR:  w_state_nxt = DISCARD;
                MEM_ADDR: w_state_nxt = (r_is_store || DUMMY_WORDS == 0) ? MEM_DATA : WAIT;
                WAIT:     w_state_nxt = (r_wait_cnt == c_wait_last) ? MEM_DATA : WAIT;
                MEM_DATA: w_state_nxt = RESUME;
                RESUME:   w_state_nxt = DISCARD;
                default:  w_state_nxt = BOOT;
            endcase
        end
    end

    // BOOT is also the reset state, so its redirect is held off while in reset.
    always_comb begin
        o_ctrl_stall        = (r_state != FETCH);
        o_ctrl_sqi_redirect = 1'b0;
        o_ctrl_sqi_wr_en    = 1'b0;
        o_ctrl_sqi_slice    = '0;
        o_ctrl_mem_ack      = 1'b0;
        o_ctrl_mem_rvld     = 1'b0;
        o_ctrl_mem_rdata    = '0;
        o_ctrl_instr_vld    = 1'b0;
        case (r_state)
            BOOT: begin
                if (i_ctrl_rst_n) begin
                    o_ctrl_sqi_redirect = 1'b1;
                    o_ctrl_sqi_slice    = word_slice(RESET_VEC, r_ctr);
                end
            end
            FETCH: o_ctrl_instr_vld = i_ctrl_sqi_ivld;
            BR_ADDR: begin
                o_ctrl_sqi_redirect = 1'b1;
                o_ctrl_sqi_slice    = i_ctrl_br_slice;
            end
            MEM_ADDR: begin
                o_ctrl_sqi_redirect = 1'b1;
                o_ctrl_sqi_slice    = i_ctrl_mem_addr;
            end
            MEM_DATA: begin
                o_ctrl_mem_ack = w_word_end;
                if (r_is_store) begin
                    o_ctrl_sqi_wr_en = 1'b1;
                    o_ctrl_sqi_slice = i_ctrl_mem_wdata;
                end else begin
                    o_ctrl_mem_rvld  = 1'b1;
                    o_ctrl_mem_rdata = i_ctrl_sqi_slice;
                end
            end
            RESUME: begin
                o_ctrl_sqi_redirect = 1'b1;
                o_ctrl_sqi_slice    = i_ctrl_pc_slice;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
